letc_core_mem_arbiter: RTL
==========================

Name: letc_core_mem_arbiter

Overview:
Shares the core's single 32-bit memory port between two requesters: the instruction-fetch stage (IF) and the load/store stage (LS). Only one transaction is outstanding at a time. LS has priority, with an anti-starvation counter that guarantees IF forward progress. Sits between the core pipeline and the core-side cache/bus interface.

Parameters:
STARVE_LIMIT, 4, consecutive LS grants allowed while IF is pending before IF is forced to win (range 1..15)

Ports:
i_clk  in  1  core clock; all state updates on rising edge
i_rst  in  1  asynchronous, active-high reset
i_if_req_valid  in  1  IF fetch request pending
o_if_req_ready  out  1  IF request accepted this cycle
i_if_addr  in  32  IF fetch address (word_t)
o_if_rsp_valid  out  1  IF response valid, 1-cycle pulse
o_if_rsp_data  out  32  fetched instruction word
i_ls_req_valid  in  1  LS request pending
o_ls_req_ready  out  1  LS request accepted this cycle
i_ls_addr  in  32  LS address
i_ls_wen  in  1  1 = store, 0 = load
i_ls_wdata  in  32  store data
i_ls_wstrb  in  4  store byte strobes
o_ls_rsp_valid  out  1  LS response valid, 1-cycle pulse (loads and stores)
o_ls_rsp_data  out  32  load data (don't-care for stores)
o_mem_req_valid  out  1  memory request valid
i_mem_req_ready  in  1  memory accepts request
o_mem_addr  out  32  memory address
o_mem_wen  out  1  memory write enable
o_mem_wdata  out  32  memory write data
o_mem_wstrb  out  4  memory byte strobes
i_mem_rsp_valid  in  1  memory response; exactly one per accepted request
i_mem_rsp_data  in  32  memory read data
o_proto_err  out  1  sticky: response received with no outstanding request

Behaviour:
- Reset (async, active-high):
  - State = IDLE; starve counter = 0; o_proto_err = 0.
  - All valid/ready outputs = 0; all data/addr/strobe outputs = 0.
  - Any in-flight transaction is dropped.
- FSM states: IDLE, ISSUE, WAIT. Owner register records IF or LS.
- IDLE:
  - If any request is valid, select a winner; assert the winner's o_*_req_ready combinationally this cycle (the other ready stays 0).
  - Latch the winner's payload into the mem_* output registers (IF: wen = 0, wstrb = 4'b0, wdata = 0); record the owner; go to ISSUE.
  - With no valid request, stay in IDLE.
- Winner selection:
  - LS wins if both are valid, unless starve_cnt == STARVE_LIMIT; then IF wins.
  - Otherwise the sole valid requester wins.
- Starve counter:
  - LS grant while i_if_req_valid = 1: increment, saturating at STARVE_LIMIT.
  - IF grant: clear to 0.
  - LS grant with IF idle: clear to 0.
  - Width = 4 bits.
- ISSUE:
  - o_mem_req_valid = 1 with stable payload until i_mem_req_ready = 1; then go to WAIT.
  - Payload and valid must not change while ready = 0.
- WAIT:
  - On i_mem_rsp_valid, register i_mem_rsp_data into the owner's rsp_data and pulse the owner's rsp_valid in the next cycle; go to IDLE.
  - The non-owner's rsp_valid stays 0.
  - rsp_data holds its value until the next response to that requester.
- Latency (zero-wait memory): ready at cycle 0 → mem_req_valid at cycle 1 → rsp at cycle 2 at earliest → o_*_rsp_valid at cycle 3.
  - Back-to-back: the next ready can assert in cycle 3, since IDLE is re-entered in the cycle after the response.
  - Maximum throughput: one transaction per 3 cycles.
- Requesters hold valid and payload until ready; payload is sampled only in the ready cycle. A requester dropping valid before ready is legal (no grant issued).
- i_mem_rsp_valid in IDLE or ISSUE: ignored (no rsp pulse, no state change); sets o_proto_err, which stays set until reset.
- i_mem_req_ready outside ISSUE: ignored.
- Reset asserted mid-ISSUE or mid-WAIT: immediate return to IDLE. A stale response arriving after reset sets o_proto_err.

Test Plan:
- Single IF fetch, addr 0x0000_1000, memory returns 0x0000_0013 with zero wait → if_ready at cycle 0, mem_req_valid at cycle 1 with addr 0x1000 and wen 0, if_rsp_valid pulse at cycle 3 with data 0x13; ls_rsp_valid never asserts.
- LS store addr 0x2000, wdata 0xDEADBEEF, wstrb 4'b0011, i_mem_req_ready held low 5 cycles → mem payload stable all 5 cycles; exactly one ls_rsp_valid after the response.
- IF and LS both valid continuously, STARVE_LIMIT = 4 → grant order LS, LS, LS, LS, IF, LS, …; the counter reads 0 after the IF grant.
- i_mem_rsp_valid pulsed while IDLE → no rsp pulse on either side; o_proto_err = 1 and stays 1 until i_rst.
- Reset asserted during WAIT with the LS owner → all outputs 0 immediately; a later LS request completes normally with correct data.
- Simultaneous IF and LS valid with starve_cnt = 0 and IF dropping valid the next cycle → LS granted; counter increments to 1; no IF grant occurs.

Source files
------------

// File: rtl/letc_core_mem_arbiter.sv
// Two-requester (IF / LS) arbiter for the core's single memory port.
// One outstanding transaction; LS priority with an IF anti-starvation counter.
module letc_core_mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_if_req_valid,
    output logic        o_if_req_ready,
    input  logic [31:0] i_if_addr,
    output logic        o_if_rsp_valid,
    output logic [31:0] o_if_rsp_data,
    input  logic        i_ls_req_valid,
    output logic        o_ls_req_ready,
    input  logic [31:0] i_ls_addr,
    input  logic        i_ls_wen,
    input  logic [31:0] i_ls_wdata,
    input  logic [3:0]  i_ls_wstrb,
    output logic        o_ls_rsp_valid,
    output logic [31:0] o_ls_rsp_data,
    output logic        o_mem_req_valid,
    input  logic        i_mem_req_ready,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_wstrb,
    input  logic        i_mem_rsp_valid,
    input  logic [31:0] i_mem_rsp_data,
    output logic        o_proto_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    localparam logic       OWN_IF  = 1'b0;
    localparam logic       OWN_LS  = 1'b1;

    localparam logic [3:0] LIMIT   = 4'(STARVE_LIMIT);

    logic [1:0]  state_q,        state_d;
    logic        owner_q,        owner_d;
    logic [3:0]  starve_q,       starve_d;
    logic [31:0] mem_addr_q,     mem_addr_d;
    logic        mem_wen_q,      mem_wen_d;
    logic [31:0] mem_wdata_q,    mem_wdata_d;
    logic [3:0]  mem_wstrb_q,    mem_wstrb_d;
    logic        if_rsp_valid_q, if_rsp_valid_d;
    logic [31:0] if_rsp_data_q,  if_rsp_data_d;
    logic        ls_rsp_valid_q, ls_rsp_valid_d;
    logic [31:0] ls_rsp_data_q,  ls_rsp_data_d;
    logic        proto_err_q,    proto_err_d;

    logic        grant_if;
    logic        grant_ls;

    // Grants are gated by reset so no ready escapes while reset is held.
    always_comb begin
        grant_if = 1'b0;
        grant_ls = 1'b0;
        if (state_q == S_IDLE && !i_rst) begin
            if (i_if_req_valid && (!i_ls_req_valid || starve_q == LIMIT)) begin
                grant_if = 1'b1;
            end else if (i_ls_req_valid) begin
                grant_ls = 1'b1;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        starve_d       = starve_q;
        mem_addr_d     = mem_addr_q;
        mem_wen_d      = mem_wen_q;
        mem_wdata_d    = mem_wdata_q;
        mem_wstrb_d    = mem_wstrb_q;
        if_rsp_valid_d = 1'b0;
        if_rsp_data_d  = if_rsp_data_q;
        ls_rsp_valid_d = 1'b0;
        ls_rsp_data_d  = ls_rsp_data_q;
        proto_err_d    = proto_err_q;

        case (state_q)
            S_IDLE: begin
                if (grant_if) begin
                    mem_addr_d  = i_if_addr;
                    mem_wen_d   = 1'b0;
                    mem_wdata_d = '0;
                    mem_wstrb_d = '0;
                    owner_d     = OWN_IF;
                    starve_d    = '0;
                    state_d     = S_ISSUE;
                end else if (grant_ls) begin
                    mem_addr_d  = i_ls_addr;
                    mem_wen_d   = i_ls_wen;
                    mem_wdata_d = i_ls_wdata;
                    mem_wstrb_d = i_ls_wstrb;
                    owner_d     = OWN_LS;
                    if (!i_if_req_valid) begin
                        starve_d = '0;
                    end else if (starve_q != LIMIT) begin
                        starve_d = starve_q + 4'd1;
                    end
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (i_mem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_mem_rsp_valid) begin
                    if (owner_q == OWN_LS) begin
                        ls_rsp_valid_d = 1'b1;
                        ls_rsp_data_d  = i_mem_rsp_data;
                    end else begin
                        if_rsp_valid_d = 1'b1;
                        if_rsp_data_d  = i_mem_rsp_data;
                    end
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (i_mem_rsp_valid && state_q != S_WAIT) begin
            proto_err_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q        <= S_IDLE;
            owner_q        <= OWN_IF;
            starve_q       <= '0;
            mem_addr_q     <= '0;
            mem_wen_q      <= 1'b0;
            mem_wdata_q    <= '0;
            mem_wstrb_q    <= '0;
            if_rsp_valid_q <= 1'b0;
            if_rsp_data_q  <= '0;
            ls_rsp_valid_q <= 1'b0;
            ls_rsp_data_q  <= '0;
            proto_err_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            starve_q       <= starve_d;
            mem_addr_q     <= mem_addr_d;
            mem_wen_q      <= mem_wen_d;
            mem_wdata_q    <= mem_wdata_d;
            mem_wstrb_q    <= mem_wstrb_d;
            if_rsp_valid_q <= if_rsp_valid_d;
            if_rsp_data_q  <= if_rsp_data_d;
            ls_rsp_valid_q <= ls_rsp_valid_d;
            ls_rsp_data_q  <= ls_rsp_data_d;
            proto_err_q    <= proto_err_d;
        end
    end

    assign o_if_req_ready  = grant_if;
    assign o_ls_req_ready  = grant_ls;
    assign o_mem_req_valid = (state_q == S_ISSUE);
    assign o_mem_addr      = mem_addr_q;
    assign o_mem_wen       = mem_wen_q;
    assign o_mem_wdata     = mem_wdata_q;
    assign o_mem_wstrb     = mem_wstrb_q;
    assign o_if_rsp_valid  = if_rsp_valid_q;
    assign o_if_rsp_data   = if_rsp_data_q;
    assign o_ls_rsp_valid  = ls_rsp_valid_q;
    assign o_ls_rsp_data   = ls_rsp_data_q;
    assign o_proto_err     = proto_err_q;

endmodule
